vx_commit_arb: RTL
==================

VX_COMMIT_ARB -- requirements
Module: VX_commit_arb

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of commit source channels (1..16).
REQ-002 SHALL have parameter NUM_LANES, default `NUM_THREADS: lanes per commit beat.
REQ-003 SHALL have parameter PID_WIDTH, default `LOG2UP(`NUM_THREADS / NUM_LANES): packet-id width.
REQ-004 SHALL have parameter BUF_DEPTH, default 4: per-input buffer entries, power of 2, >= 2.
REQ-005 SHALL have port clk  input  1: sole clock, rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  NUM_INPUTS: per-channel beat valid.
REQ-008 SHALL have port in_data  input  NUM_INPUTS x COMMIT_DATAW: per-channel commit beat (uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop).
REQ-009 SHALL have port in_ready  output  NUM_INPUTS: per-channel accept.
REQ-010 SHALL have port out_valid  output  1; out_data  output  COMMIT_DATAW; out_ready  input  1.
REQ-011 SHALL have port out_sel  output  `LOG2UP(NUM_INPUTS): source channel of out_data.

Function
REQ-012 SHALL buffer each channel in its own BUF_DEPTH FIFO; in_ready[i] = !full[i], registered, independent of out_ready.
REQ-013 SHALL accept no push into a full FIFO even when a pop occurs that cycle.
REQ-014 SHALL arbitrate round-robin among non-empty FIFOs; priority pointer advances to (granted+1) mod NUM_INPUTS after each eop beat transfers.
REQ-015 SHALL run a two-state grant FSM: IDLE (arbitrate each beat) and LOCKED (grant fixed to one channel).
REQ-016 SHALL move IDLE->LOCKED when a beat with sop=1, eop=0 transfers into the output register; LOCKED->IDLE when the locked channel's eop=1 beat transfers.
REQ-017 SHALL, in LOCKED, ignore other channels even when the locked FIFO is empty (no packet interleave).
REQ-018 SHALL treat a beat with sop=1, eop=1 as a single-beat packet; no FSM state change.
REQ-019 SHALL hold out_data registered; out_valid/out_data/out_sel stable while out_valid && !out_ready.
REQ-020 SHALL refill the output register in the same cycle it is drained (full throughput: 1 beat/cycle).
REQ-021 SHALL give minimum latency 2 cycles: in handshake at edge t -> out_valid at t+2 edge.
REQ-022 SHALL preserve per-channel beat order; data fields pass unmodified.

Reset
REQ-023 SHALL on reset: all FIFOs empty, in_ready all 1 from the cycle after reset deasserts, out_valid=0, out_data=0, out_sel=0, FSM=IDLE, priority pointer=0.
REQ-024 SHALL discard in-flight packets and release any lock on reset asserted mid-packet; no partial beat emitted afterwards.

Configuration
REQ-025 SHALL, with VX_COMMIT_PERF_EN defined, add outputs perf_commits  NUM_INPUTS x 44 (eop transfers per channel) and perf_stalls  44 (cycles out_valid && !out_ready), cleared on reset, wrapping at 2^44.
REQ-026 SHALL, without VX_COMMIT_PERF_EN, omit those ports and counters entirely.

Structure
REQ-027 SHALL place the commit beat struct, COMMIT_DATAW and the FSM state enum in VX_gpu_pkg.
REQ-028 SHALL implement the per-channel FIFO as sub-module VX_commit_arb_buf, instantiated NUM_INPUTS times.

Verification
REQ-029 SHALL cover: reset, single beat ch0 (sop=1,eop=1,PC=0x80000000), out_ready=1 -> out_valid at cycle 2, out_sel=0, PC intact.
REQ-030 SHALL cover: ch0..ch3 each push single-beat packets continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0 with no idle cycle.
REQ-031 SHALL cover: ch1 3-beat packet (sop, mid, eop) with 1-cycle gap before eop while ch2 valid -> output ch1,ch1,ch1 then ch2; no ch2 beat between.
REQ-032 SHALL cover: out_ready=0 for 10 cycles, ch0 pushing -> in_ready[0]=0 after BUF_DEPTH accepts (+1 in output register); out_data stable throughout.
REQ-033 SHALL cover: reset asserted after sop of 4-beat packet -> FSM IDLE, out_valid=0 next cycle, remaining beats never appear.
REQ-034 SHALL cover (VX_COMMIT_PERF_EN): 5 packets on ch3 with 7 stall cycles -> perf_commits[3]=5, perf_stalls=7.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Shared commit-path types: commit beat layout, its width, and the commit arbiter grant states.
// sop/eop sit in the two LSBs so the arbiter can find them at any lane/pid width.
package vx_gpu_pkg;

   localparam int NUM_THREADS   = 4;
   localparam int UUID_WIDTH    = 44;
   localparam int NW_WIDTH      = 2;
   localparam int NUM_REGS_BITS = 5;
   localparam int XLEN          = 32;
   localparam int PERF_W        = 44;
   localparam int EOP_BIT       = 0;
   localparam int SOP_BIT       = 1;

   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PID_WIDTH_DEF = log2up(NUM_THREADS / NUM_THREADS);

   typedef struct packed {
      logic [UUID_WIDTH-1:0]               uuid;
      logic [NW_WIDTH-1:0]                 wid;
      logic [NUM_THREADS-1:0]              tmask;
      logic [XLEN-1:0]                     pc;
      logic                                wb;
      logic [NUM_REGS_BITS-1:0]            rd;
      logic [NUM_THREADS-1:0][XLEN-1:0]    data;
      logic [PID_WIDTH_DEF-1:0]            pid;
      logic                                sop;
      logic                                eop;
   } commit_t;

   localparam int COMMIT_DATAW = $bits(commit_t);

   // Beat width for non-default lane/pid configurations; matches commit_t at the defaults.
   function automatic int commit_dataw(input int lanes, input int pid_w);
      return UUID_WIDTH + NW_WIDTH + lanes + XLEN + 1 + NUM_REGS_BITS + lanes * XLEN + pid_w + 2;
   endfunction

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vx_commit_arb_buf.sv
// Per-channel commit FIFO. push_ready is registered from the post-update occupancy;
// head_valid deliberately ignores the current cycle's push, giving a 2-cycle in-to-out latency.
module vx_commit_arb_buf #(
   parameter int DATAW = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_valid,
   input  logic [DATAW-1:0] push_data,
   output logic             push_ready,
   input  logic             pop,
   output logic             head_valid,
   output logic [DATAW-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATAW-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count, count_pop, count_n;
   logic             push, do_pop;

   assign push      = push_valid && push_ready;
   assign do_pop    = pop && head_valid;
   assign count_pop = count - CW'(do_pop);
   assign count_n   = count_pop + CW'(push);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         push_ready <= 1'b0;
         head_valid <= 1'b0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count      <= count_n;
         push_ready <= (count_n != CW'(DEPTH));
         head_valid <= (count_pop != '0);
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: per-channel FIFOs, round-robin grant with packet lock, registered output.
// Optional macro VX_COMMIT_PERF_EN adds per-channel commit and output-stall counters.
module vx_commit_arb import vx_gpu_pkg::*; #(
   parameter int  NUM_INPUTS = 4,
   parameter int  NUM_LANES  = NUM_THREADS,
   parameter int  PID_WIDTH  = log2up(NUM_THREADS / NUM_LANES),
   parameter int  BUF_DEPTH  = 4,
   localparam int DATAW      = commit_dataw(NUM_LANES, PID_WIDTH),
   localparam int SELW       = log2up(NUM_INPUTS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_INPUTS-1:0]             in_valid,
   input  logic [NUM_INPUTS-1:0][DATAW-1:0]  in_data,
   output logic [NUM_INPUTS-1:0]             in_ready,
   output logic                              out_valid,
   output logic [DATAW-1:0]                  out_data,
   input  logic                              out_ready,
   output logic [SELW-1:0]                   out_sel
`ifdef VX_COMMIT_PERF_EN
   ,
   output logic [NUM_INPUTS-1:0][PERF_W-1:0] perf_commits,
   output logic [PERF_W-1:0]                 perf_stalls
`endif
);

   logic [NUM_INPUTS-1:0] avail, pop;
   logic [DATAW-1:0]      head [NUM_INPUTS];

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_buf
      vx_commit_arb_buf #(
         .DATAW (DATAW),
         .DEPTH (BUF_DEPTH)
      ) u_buf (
         .clk        (clk),
         .reset      (reset),
         .push_valid (in_valid[i]),
         .push_data  (in_data[i]),
         .push_ready (in_ready[i]),
         .pop        (pop[i]),
         .head_valid (avail[i]),
         .head_data  (head[i])
      );
   end

   arb_state_e       state, state_n;
   logic [SELW-1:0]  lock_ch, lock_ch_n, rr_ptr, rr_ptr_n, grant, scan;
   logic             grant_ok, load, xfer;
   logic [DATAW-1:0] grant_data;

   // The output register reloads whenever it is empty or being drained this cycle.
   assign load       = !out_valid || out_ready;
   assign xfer       = load && grant_ok;
   assign grant_data = head[grant];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      scan     = '0;
      if (state == ARB_LOCKED) begin
         grant    = lock_ch;
         grant_ok = avail[lock_ch];
      end else begin
         // Scan downwards so the channel closest to rr_ptr is the last, winning, assignment.
         for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            scan = SELW'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (avail[scan]) begin
               grant    = scan;
               grant_ok = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pop       = '0;
      state_n   = state;
      lock_ch_n = lock_ch;
      rr_ptr_n  = rr_ptr;
      if (xfer) begin
         pop[grant] = 1'b1;
         if (grant_data[EOP_BIT]) begin
            state_n  = ARB_IDLE;
            rr_ptr_n = SELW'((int'(grant) + 1) % NUM_INPUTS);
         end else if (grant_data[SOP_BIT]) begin
            state_n   = ARB_LOCKED;
            lock_ch_n = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         lock_ch   <= '0;
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else begin
         state   <= state_n;
         lock_ch <= lock_ch_n;
         rr_ptr  <= rr_ptr_n;
         if (load) begin
            out_valid <= grant_ok;
            if (grant_ok) begin
               out_data <= grant_data;
               out_sel  <= grant;
            end
         end
      end
   end

`ifdef VX_COMMIT_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_commits <= '0;
         perf_stalls  <= '0;
      end else begin
         if (out_valid && out_ready && out_data[EOP_BIT])
            perf_commits[out_sel] <= perf_commits[out_sel] + PERF_W'(1);
         if (out_valid && !out_ready)
            perf_stalls <= perf_stalls + PERF_W'(1);
      end
   end
`endif

endmodule
